// File: rtl/joy_db9_scanner.sv
// DB9 joystick port scanner: drives the pin-7 select, demultiplexes Atari / Mega Drive
// 3-button pads over two select phases and debounces the result over whole scans.
module joy_db9_scanner #(
  parameter logic [15:0] CLK_MHZ  = 16'd50,
  parameter logic [15:0] SCAN_US  = 16'd10,
  parameter logic [3:0]  DEBOUNCE = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joyp1_i,
  input  logic       joyp2_i,
  input  logic       joyp3_i,
  input  logic       joyp4_i,
  input  logic       joyp6_i,
  input  logic       joyp9_i,
  output logic       joyp7_o,
  output logic [7:0] joy_state,
  output logic       md_pad,
  output logic       joy_changed,
  output logic       scan_done
);

  localparam logic [31:0] PHASE_LAST = ({16'd0, CLK_MHZ} * {16'd0, SCAN_US}) - 32'd1;

  typedef enum logic {PH_HI, PH_LO} phase_e;

  phase_e      state_q, state_d;
  logic [5:0]  syncMeta_q, syncPins_q;
  logic [31:0] presc_q, presc_d;
  logic [5:0]  hiBits_q, hiBits_d;
  logic [8:0]  cand_q, cand_d;
  logic [8:0]  out_q, out_d;
  logic [3:0]  matchCnt_q, matchCnt_d;
  logic        changed_q, changed_d;

  logic [5:0]  pinLow;
  logic        phaseEnd;
  logic        rawMd;
  logic [8:0]  scanVec;

  // Pins are packed {p9,p6,p4,p3,p2,p1}; idle level is high, so the synchroniser resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta_q <= '1;
      syncPins_q <= '1;
    end else begin
      syncMeta_q <= {joyp9_i, joyp6_i, joyp4_i, joyp3_i, joyp2_i, joyp1_i};
      syncPins_q <= syncMeta_q;
    end
  end

  assign pinLow   = ~syncPins_q;
  assign phaseEnd = (presc_q == PHASE_LAST);
  assign rawMd    = pinLow[2] & pinLow[3];
  // Inverted pin order already matches {C,B,right,left,down,up}; an Atari pad has no A/Start.
  assign scanVec  = {rawMd, rawMd & pinLow[5], rawMd & pinLow[4], hiBits_q};

  always_comb begin
    state_d    = state_q;
    presc_d    = phaseEnd ? 32'd0 : presc_q + 32'd1;
    hiBits_d   = hiBits_q;
    cand_d     = cand_q;
    matchCnt_d = matchCnt_q;
    out_d      = out_q;
    changed_d  = 1'b0;
    joyp7_o    = (state_q == PH_HI);
    scan_done  = 1'b0;
    unique case (state_q)
      PH_HI: begin
        if (phaseEnd) begin
          hiBits_d = pinLow;
          state_d  = PH_LO;
        end
      end
      PH_LO: begin
        if (phaseEnd) begin
          state_d   = PH_HI;
          scan_done = 1'b1;
          if (scanVec != cand_q) begin
            cand_d     = scanVec;
            matchCnt_d = 4'd1;
          end else if (matchCnt_q < DEBOUNCE) begin
            matchCnt_d = matchCnt_q + 4'd1;
          end
          if (matchCnt_d == DEBOUNCE) begin
            out_d     = cand_d;
            changed_d = (cand_d != out_q);
          end
        end
      end
      default: state_d = PH_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PH_HI;
      presc_q    <= 32'd0;
      hiBits_q   <= 6'd0;
      cand_q     <= 9'd0;
      matchCnt_q <= 4'd0;
      out_q      <= 9'd0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hiBits_q   <= hiBits_d;
      cand_q     <= cand_d;
      matchCnt_q <= matchCnt_d;
      out_q      <= out_d;
      changed_q  <= changed_d;
    end
  end

  assign joy_state   = out_q[7:0];
  assign md_pad      = out_q[8];
  assign joy_changed = changed_q;

endmodule

// File: tb/tb_joy_db9_scanner.sv
// Bench for joy_db9_scanner: a behavioural pad answers the select line, and a scan-level
// model (history of whole-scan vectors) predicts the debounced output.
module tb_joy_db9_scanner;

  localparam int DEB = 3;
  localparam logic [7:0] B_UP = 8'h01, B_DOWN = 8'h02, B_B = 8'h10, B_START = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       joyp1, joyp2, joyp3, joyp4, joyp6, joyp9;
  logic       joyp7;
  logic [7:0] joy_state;
  logic       md_pad, joy_changed, scan_done;

  // Pad intent: padMd selects a Mega Drive pad, padBtn is {start,A,C,B,right,left,down,up}.
  logic       padMd = 1'b0;
  logic [7:0] padBtn = 8'h00;

  int         nAsserts = 0;
  int         nFails = 0;
  int         pulseCount = 0;
  bit         firstScan = 1'b1;
  logic [8:0] hist[$];
  logic [8:0] expOut = 9'd0;

  joy_db9_scanner #(.CLK_MHZ(16'd50), .SCAN_US(16'd1), .DEBOUNCE(4'd3)) dut (
    .clk(clk), .reset(reset),
    .joyp1_i(joyp1), .joyp2_i(joyp2), .joyp3_i(joyp3), .joyp4_i(joyp4),
    .joyp6_i(joyp6), .joyp9_i(joyp9),
    .joyp7_o(joyp7), .joy_state(joy_state), .md_pad(md_pad),
    .joy_changed(joy_changed), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // A Mega Drive pad pulls pins 3/4 low and multiplexes A/Start onto 6/9 while select is low.
  assign joyp1 = ~padBtn[0];
  assign joyp2 = ~padBtn[1];
  assign joyp3 = (padMd && !joyp7) ? 1'b0 : ~padBtn[2];
  assign joyp4 = (padMd && !joyp7) ? 1'b0 : ~padBtn[3];
  assign joyp6 = (padMd && !joyp7) ? ~padBtn[6] : ~padBtn[4];
  assign joyp9 = (padMd && !joyp7) ? ~padBtn[7] : ~padBtn[5];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic md, input logic [7:0] btn);
    padMd  = md;
    padBtn = btn;
  endtask

  // What one full scan reports for a given pad: {md, start, A, C, B, right, left, down, up}.
  // An Atari pad holding left+right looks like a Mega Drive pad to the detect logic.
  function automatic logic [8:0] expectScan(input logic md, input logic [7:0] b);
    logic       detect;
    logic [1:0] lo;
    if (md) begin
      detect = 1'b1;
      lo     = {b[7], b[6]};
    end else begin
      detect = b[2] & b[3];
      lo     = {b[5], b[4]};
    end
    return {detect, detect ? lo : 2'b00, b[5:0]};
  endfunction

  task automatic modelReset();
    hist.delete();
    expOut    = 9'd0;
    firstScan = 1'b1;
  endtask

  // Wait for one scan to finish, then check the commit cycle against the scan-history model.
  task automatic scanStep();
    int         n = 0;
    int         fallAt = -1;
    logic       stray = 1'b0;
    logic       changedExp = 1'b0;
    logic       same;
    logic [8:0] last;
    while (scan_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (joy_changed === 1'b1) stray = 1'b1;
      if (fallAt < 0 && joyp7 === 1'b0) fallAt = n;
    end
    if (scan_done !== 1'b1) begin
      checkOutput("scan_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("stray_changed", {31'd0, stray}, 32'd0);
    checkOutput("sel_lo_at_done", {31'd0, joyp7}, 32'd0);
    if (!firstScan) begin
      checkOutput("scan_period", n, 99);
      checkOutput("select_fall", fallAt, 50);
    end
    hist.push_back(expectScan(padMd, padBtn));
    if (hist.size() >= DEB) begin
      last = hist[hist.size()-1];
      same = 1'b1;
      for (int k = 1; k < DEB; k++)
        if (hist[hist.size()-1-k] != last) same = 1'b0;
      if (same) begin
        changedExp = (last != expOut);
        expOut     = last;
      end
    end
    @(negedge clk);
    checkOutput("joy_state", {24'd0, joy_state}, {24'd0, expOut[7:0]});
    checkOutput("md_pad", {31'd0, md_pad}, {31'd0, expOut[8]});
    checkOutput("joy_changed", {31'd0, joy_changed}, {31'd0, changedExp});
    checkOutput("sel_hi_after_done", {31'd0, joyp7}, 32'd1);
    checkOutput("scan_done_1cyc", {31'd0, scan_done}, 32'd0);
    if (joy_changed === 1'b1) pulseCount++;
    firstScan = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0;
    int n;

    // Reset state and idle scanning with no pad.
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("rst_joy_state", {24'd0, joy_state}, 32'd0);
    checkOutput("rst_md_pad", {31'd0, md_pad}, 32'd0);
    checkOutput("rst_select", {31'd0, joyp7}, 32'd1);
    checkOutput("rst_scan_done", {31'd0, scan_done}, 32'd0);
    checkOutput("rst_changed", {31'd0, joy_changed}, 32'd0);
    reset = 1'b0;
    modelReset();
    repeat (4) scanStep();
    checkOutput("idle_pulses", pulseCount, 0);

    // Atari pad: up + fire on pin 6.
    p0 = pulseCount;
    applyStimulus(1'b0, B_UP | B_B);
    repeat (4) scanStep();
    checkOutput("atari_state", {24'd0, joy_state}, {24'd0, B_UP | B_B});
    checkOutput("atari_md", {31'd0, md_pad}, 32'd0);
    checkOutput("atari_pulses", pulseCount - p0, 1);

    // Reset at cycle 30 of PH_LO with a button committed.
    repeat (80) @(negedge clk);
    checkOutput("pre_rst_select", {31'd0, joyp7}, 32'd0);
    checkOutput("pre_rst_state", {24'd0, joy_state}, {24'd0, B_UP | B_B});
    reset = 1'b1;
    #1;
    checkOutput("midrst_joy_state", {24'd0, joy_state}, 32'd0);
    checkOutput("midrst_select", {31'd0, joyp7}, 32'd1);
    checkOutput("midrst_md", {31'd0, md_pad}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset();
    n = 0;
    while (joyp7 !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("post_rst_phase", n, 50);
    repeat (4) scanStep();
    checkOutput("post_rst_state", {24'd0, joy_state}, {24'd0, B_UP | B_B});

    // Mega Drive pad: B in the high phase, Start in the low phase.
    applyStimulus(1'b1, B_START | B_B);
    repeat (4) scanStep();
    checkOutput("md_state", {24'd0, joy_state}, {24'd0, B_START | B_B});
    checkOutput("md_flag", {31'd0, md_pad}, 32'd1);

    // Pad removed: state and mode drop together with one pulse.
    p0 = pulseCount;
    applyStimulus(1'b0, 8'h00);
    repeat (4) scanStep();
    checkOutput("removed_state", {24'd0, joy_state}, 32'd0);
    checkOutput("removed_md", {31'd0, md_pad}, 32'd0);
    checkOutput("removed_pulses", pulseCount - p0, 1);

    // Down bouncing on alternate scans never commits; holding it does.
    p0 = pulseCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? B_DOWN : 8'h00);
      scanStep();
    end
    checkOutput("bounce_state", {24'd0, joy_state}, 32'd0);
    checkOutput("bounce_pulses", pulseCount - p0, 0);
    applyStimulus(1'b0, B_DOWN);
    repeat (3) scanStep();
    checkOutput("held_down", {24'd0, joy_state}, {24'd0, B_DOWN});

    // Random pads and buttons held for random numbers of scans.
    for (int r = 0; r < 12; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
      repeat ($urandom_range(1, 5)) scanStep();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
